// File: rtl/mod_148_dplca_pkg.sv
// Shared definitions for the DPLCA TXOP aging / table-scan blocks.
//
// Contents:
//   - claim encodings (SOFT/HARD/NONE; 2'b11 is reserved and read as NONE)
//   - scan state encodings (IDLE/CAPTURE/SCAN/PUBLISH)
//   - table geometry: 256 entries of 2 bits each
//   - is_claimed(): true for SOFT or HARD
package mod_148_dplca_pkg;

    localparam int TABLE_DEPTH = 256;
    localparam int ENTRY_W     = 2;
    localparam int ID_W        = 8;
    localparam int COUNT_W     = 9;
    // Per-lane-group count width; covers up to 16 lanes.
    localparam int LANE_CNT_W  = 5;

    typedef enum logic [1:0] {
        CLAIM_SOFT = 2'b00,
        CLAIM_HARD = 2'b01,
        CLAIM_NONE = 2'b10
    } claim_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SCAN    = 2'd2,
        ST_PUBLISH = 2'd3
    } scan_state_e;

    function automatic logic is_claimed(input logic [ENTRY_W-1:0] entry);
        return (entry == CLAIM_SOFT) || (entry == CLAIM_HARD);
    endfunction

endpackage

// File: rtl/dplca_claim_lane_reduce.sv
// Combinational reduction of LANES consecutive claim-table entries.
//
// Ports:
//   entries         in  LANES*2  entry i of the group at bits [2i+1:2i]
//   base            in  8        table ID of entry 0 of the group
//   lane_any        out 1        at least one SOFT/HARD entry in the group
//   lane_max        out 8        highest claimed ID in the group (0 if none)
//   lane_count      out 5        number of claimed entries in the group
//   lane_free       out 8        lowest non-claimed ID >= 1 in the group
//   lane_free_valid out 1        lane_free is meaningful
module dplca_claim_lane_reduce
    import mod_148_dplca_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic [ENTRY_W*LANES-1:0] entries,
    input  logic [ID_W-1:0]          base,
    output logic                     lane_any,
    output logic [ID_W-1:0]          lane_max,
    output logic [LANE_CNT_W-1:0]    lane_count,
    output logic [ID_W-1:0]          lane_free,
    output logic                     lane_free_valid
);

    always_comb begin
        lane_any        = 1'b0;
        lane_max        = '0;
        lane_count      = '0;
        lane_free       = '0;
        lane_free_valid = 1'b0;
        // Ascending walk: the last claimed entry wins for max, the first
        // unclaimed one wins for free. ID 0 is the coordinator, never free.
        for (int i = 0; i < LANES; i++) begin
            if (is_claimed(entries[ENTRY_W*i +: ENTRY_W])) begin
                lane_any   = 1'b1;
                lane_max   = base + ID_W'(i);
                lane_count = lane_count + LANE_CNT_W'(1);
            end else if (!lane_free_valid && ((base + ID_W'(i)) != '0)) begin
                lane_free       = base + ID_W'(i);
                lane_free_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dplca_table_scan.sv
// DPLCA TXOP claim-table scanner.
//
// On a rising edge of (dplca_txop_table_upd | dplca_new_age) the 256-entry
// claim table is snapshotted and reduced LANES entries per clock. Results
// are published together with a one-cycle scan_done pulse and held until
// the next publish. Triggers arriving while a scan is in flight collapse
// into one rescan.
//
// Optional build macro: DPLCA_NODE_COUNT_MARGIN_EN adds NODE_COUNT_MARGIN
// to the derived node count whenever any entry is claimed.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   dplca_enable               0 aborts to IDLE and forces reset values
//   dplca_txop_table_upd       level; rising edge of the OR triggers a scan
//   dplca_new_age              level; rising edge of the OR triggers a scan
//   txop_claim_table_unpacked  512-bit table, entry i at [2i+1:2i]
//   scan_busy                  high in CAPTURE and SCAN
//   scan_done                  one-cycle pulse when results update
//   any_claimed, max_claimed_id, claimed_count,
//   free_id, free_valid, node_count   published results
//
// Handshake: there is no backpressure. scan_done is a single-cycle strobe;
// the result outputs are valid in that cycle and stay unchanged until the
// next strobe (or reset / dplca_enable low, which restores reset values).
module dplca_table_scan
    import mod_148_dplca_pkg::*;
#(
    parameter int LANES              = 4,
    parameter int DEFAULT_NODE_COUNT = 8,
    parameter int NODE_COUNT_MARGIN  = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              dplca_enable,
    input  logic                              dplca_txop_table_upd,
    input  logic                              dplca_new_age,
    input  logic [TABLE_DEPTH*ENTRY_W-1:0]    txop_claim_table_unpacked,
    output logic                              scan_busy,
    output logic                              scan_done,
    output logic                              any_claimed,
    output logic [ID_W-1:0]                   max_claimed_id,
    output logic [COUNT_W-1:0]                claimed_count,
    output logic [ID_W-1:0]                   free_id,
    output logic                              free_valid,
    output logic [ID_W-1:0]                   node_count
);

    localparam int            CHUNK_W    = ENTRY_W * LANES;
    localparam logic [ID_W-1:0] LAST_INDEX = ID_W'(TABLE_DEPTH - LANES);

`ifndef DPLCA_NODE_COUNT_MARGIN_EN
    localparam int unused_node_count_margin = NODE_COUNT_MARGIN;
`endif

    scan_state_e                     state, state_next;
    logic                            trig_prev;
    logic                            trig_level;
    logic                            trig;
    logic                            pending;
    logic [TABLE_DEPTH*ENTRY_W-1:0]  shadow;
    logic [ID_W-1:0]                 index;
    logic                            last_chunk;

    logic                            acc_any;
    logic [ID_W-1:0]                 acc_max;
    logic [COUNT_W-1:0]              acc_count;
    logic [ID_W-1:0]                 acc_free;
    logic                            acc_free_valid;

    logic                            lane_any;
    logic [ID_W-1:0]                 lane_max;
    logic [LANE_CNT_W-1:0]           lane_count;
    logic [ID_W-1:0]                 lane_free;
    logic                            lane_free_valid;

    logic                            nxt_any;
    logic [ID_W-1:0]                 nxt_max;
    logic [COUNT_W-1:0]              nxt_count;
    logic [ID_W-1:0]                 nxt_free;
    logic                            nxt_free_valid;
    logic [31:0]                     nc_sum;
    logic [ID_W-1:0]                 pub_node_count;

    assign trig_level = dplca_txop_table_upd | dplca_new_age;
    assign trig       = trig_level & ~trig_prev;
    assign last_chunk = (index == LAST_INDEX);

    // The shadow shifts down each SCAN cycle, so the current chunk is
    // always the low CHUNK_W bits and index only supplies the base ID.
    dplca_claim_lane_reduce #(.LANES(LANES)) u_lane_reduce (
        .entries         (shadow[CHUNK_W-1:0]),
        .base            (index),
        .lane_any        (lane_any),
        .lane_max        (lane_max),
        .lane_count      (lane_count),
        .lane_free       (lane_free),
        .lane_free_valid (lane_free_valid)
    );

    // Merge this chunk into the running accumulators.
    assign nxt_any        = acc_any | lane_any;
    assign nxt_max        = lane_any ? lane_max : acc_max;
    assign nxt_count      = acc_count + COUNT_W'(lane_count);
    assign nxt_free       = acc_free_valid ? acc_free : lane_free;
    assign nxt_free_valid = acc_free_valid | lane_free_valid;

    always_comb begin
        nc_sum = 32'(nxt_max) + 32'd1;
`ifdef DPLCA_NODE_COUNT_MARGIN_EN
        nc_sum = nc_sum + 32'(NODE_COUNT_MARGIN);
`endif
        if (!nxt_any) begin
            pub_node_count = ID_W'(DEFAULT_NODE_COUNT);
        end else if (nc_sum > 32'd255) begin
            pub_node_count = 8'd255;
        end else begin
            pub_node_count = nc_sum[ID_W-1:0];
        end
    end

    // FSM next state and status outputs.
    always_comb begin
        state_next = state;
        scan_busy  = 1'b0;
        scan_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trig || pending) state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                scan_busy  = 1'b1;
                state_next = ST_SCAN;
            end
            ST_SCAN: begin
                scan_busy = 1'b1;
                if (last_chunk) state_next = ST_PUBLISH;
            end
            ST_PUBLISH: begin
                scan_done  = 1'b1;
                state_next = pending ? ST_CAPTURE : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Edge-detect copy is cleared only by reset so a level that stays high
    // across a dplca_enable drop does not re-trigger.
    always_ff @(posedge clk) begin
        if (reset) trig_prev <= 1'b0;
        else       trig_prev <= trig_level;
    end

    always_ff @(posedge clk) begin
        if (reset || !dplca_enable) begin
            state          <= ST_IDLE;
            pending        <= 1'b0;
            shadow         <= '0;
            index          <= '0;
            acc_any        <= 1'b0;
            acc_max        <= '0;
            acc_count      <= '0;
            acc_free       <= '0;
            acc_free_valid <= 1'b0;
            any_claimed    <= 1'b0;
            max_claimed_id <= '0;
            claimed_count  <= '0;
            free_id        <= '0;
            free_valid     <= 1'b0;
            node_count     <= ID_W'(DEFAULT_NODE_COUNT);
        end else begin
            state <= state_next;

            // IDLE always leaves for CAPTURE when pending is set, so it can
            // be cleared there. In PUBLISH a held pending is consumed by the
            // rescan; a fresh trigger in that cycle is kept for later.
            if (state == ST_IDLE)         pending <= 1'b0;
            else if (state == ST_PUBLISH) pending <= pending ? 1'b0 : trig;
            else if (trig)                pending <= 1'b1;

            if (state == ST_CAPTURE) begin
                shadow         <= txop_claim_table_unpacked;
                index          <= '0;
                acc_any        <= 1'b0;
                acc_max        <= '0;
                acc_count      <= '0;
                acc_free       <= '0;
                acc_free_valid <= 1'b0;
            end else if (state == ST_SCAN) begin
                shadow         <= shadow >> CHUNK_W;
                index          <= index + ID_W'(LANES);
                acc_any        <= nxt_any;
                acc_max        <= nxt_max;
                acc_count      <= nxt_count;
                acc_free       <= nxt_free;
                acc_free_valid <= nxt_free_valid;
                // Load the results on the last chunk so they are visible in
                // the same cycle as the scan_done strobe.
                if (last_chunk) begin
                    any_claimed    <= nxt_any;
                    max_claimed_id <= nxt_max;
                    claimed_count  <= nxt_count;
                    free_id        <= nxt_free;
                    free_valid     <= nxt_free_valid;
                    node_count     <= pub_node_count;
                end
            end
        end
    end

endmodule

// File: tb/tb_dplca_table_scan.sv
// Directed bench for dplca_table_scan (LANES=4, DEFAULT_NODE_COUNT=8,
// NODE_COUNT_MARGIN=2). Expected node counts follow the build macro.
module tb_dplca_table_scan;
    import mod_148_dplca_pkg::*;

`ifdef DPLCA_NODE_COUNT_MARGIN_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif
    localparam int MARGIN  = 2;
    localparam int LATENCY = 66;

    logic         clk;
    logic         reset;
    logic         dplca_enable;
    logic         dplca_txop_table_upd;
    logic         dplca_new_age;
    logic [511:0] tbl;
    logic         scan_busy;
    logic         scan_done;
    logic         any_claimed;
    logic [7:0]   max_claimed_id;
    logic [8:0]   claimed_count;
    logic [7:0]   free_id;
    logic         free_valid;
    logic [7:0]   node_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_max_q[$];
    logic [8:0] exp_cnt_q[$];

    dplca_table_scan #(
        .LANES              (4),
        .DEFAULT_NODE_COUNT (8),
        .NODE_COUNT_MARGIN  (MARGIN)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .dplca_enable              (dplca_enable),
        .dplca_txop_table_upd      (dplca_txop_table_upd),
        .dplca_new_age             (dplca_new_age),
        .txop_claim_table_unpacked (tbl),
        .scan_busy                 (scan_busy),
        .scan_done                 (scan_done),
        .any_claimed               (any_claimed),
        .max_claimed_id            (max_claimed_id),
        .claimed_count             (claimed_count),
        .free_id                   (free_id),
        .free_valid                (free_valid),
        .node_count                (node_count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard compare
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_results(input string tag, input int any, input int mx,
                                 input int cnt, input int fid, input int fv, input int nc);
        check({tag, ".any"},   32'(any_claimed),    32'(any));
        check({tag, ".max"},   32'(max_claimed_id), 32'(mx));
        check({tag, ".count"}, 32'(claimed_count),  32'(cnt));
        check({tag, ".free"},  32'(free_id),        32'(fid));
        check({tag, ".fv"},    32'(free_valid),     32'(fv));
        check({tag, ".nc"},    32'(node_count),     32'(nc));
    endtask

    // Drivers
    task automatic fill_table(input logic [1:0] code);
        for (int i = 0; i < 256; i++) tbl[2*i +: 2] = code;
    endtask

    task automatic set_entry(input int id, input logic [1:0] code);
        tbl[2*id +: 2] = code;
    endtask

    // Pulse dplca_txop_table_upd for one cycle and wait (bounded) for
    // scan_done; returns the cycle count from the trigger cycle.
    task automatic scan_and_wait(input string tag);
        int lat;
        lat = -1;
        repeat (2) @(negedge clk);
        dplca_txop_table_upd = 1'b1;
        for (int k = 1; k <= 300 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 1) dplca_txop_table_upd = 1'b0;
            if (scan_done) lat = k;
        end
        check({tag, ".latency"}, 32'(lat), 32'(LATENCY));
    endtask

    initial begin
        int pulses;
        int first_at;
        int second_at;
        int done_seen;

        reset                = 1'b1;
        dplca_enable         = 1'b1;
        dplca_txop_table_upd = 1'b0;
        dplca_new_age        = 1'b0;
        fill_table(2'b10);
        repeat (3) @(negedge clk);

        // Reset state
        check("rst.busy", 32'(scan_busy), 0);
        check("rst.done", 32'(scan_done), 0);
        check_results("rst", 0, 0, 0, 0, 0, 8);
        reset = 1'b0;
        @(negedge clk);

        // T1: empty table
        scan_and_wait("t1");
        check_results("t1", 0, 0, 0, 1, 1, 8);
        @(negedge clk);
        check("t1.done_one_cycle", 32'(scan_done), 0);
        check("t1.busy_after", 32'(scan_busy), 0);

        // T2: ID0 SOFT, ID5 SOFT, ID200 HARD
        fill_table(2'b10);
        set_entry(0, 2'b00);
        set_entry(5, 2'b00);
        set_entry(200, 2'b01);
        scan_and_wait("t2");
        check_results("t2", 1, 200, 3, 1, 1, 201 + EXTRA);

        // T3a: IDs 0..254 claimed, ID255 free
        fill_table(2'b00);
        set_entry(255, 2'b10);
        scan_and_wait("t3a");
        check_results("t3a", 1, 254, 255, 255, 1, 255);

        // T3b: whole table claimed
        fill_table(2'b01);
        scan_and_wait("t3b");
        check("t3b.any", 32'(any_claimed), 1);
        check("t3b.max", 32'(max_claimed_id), 255);
        check("t3b.count", 32'(claimed_count), 256);
        check("t3b.fv", 32'(free_valid), 0);
        check("t3b.nc", 32'(node_count), 255);

        // T3c: ID0 NONE (coordinator, never free), ID4 reserved code -> free
        fill_table(2'b00);
        set_entry(0, 2'b10);
        set_entry(4, 2'b11);
        scan_and_wait("t3c");
        check_results("t3c", 1, 255, 254, 4, 1, 255);

        // T4: table change mid-scan ignored; second trigger queues a rescan
        fill_table(2'b10);
        set_entry(0, 2'b00);
        set_entry(5, 2'b00);
        set_entry(200, 2'b01);
        exp_max_q.push_back(8'd200);
        exp_cnt_q.push_back(9'd3);
        exp_max_q.push_back(8'd9);
        exp_cnt_q.push_back(9'd1);
        pulses    = 0;
        first_at  = -1;
        second_at = -1;
        repeat (2) @(negedge clk);
        dplca_txop_table_upd = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1) dplca_txop_table_upd = 1'b0;
            if (k == 20) begin
                fill_table(2'b10);
                set_entry(9, 2'b01);
            end
            if (k == 30) dplca_new_age = 1'b1;
            if (k == 31) dplca_new_age = 1'b0;
            if (k == 50) check("t4.hold_old", 32'(max_claimed_id), 255);
            if (scan_done) begin
                pulses++;
                if (pulses == 1) first_at = k;
                if (pulses == 2) second_at = k;
                if (exp_max_q.size() == 0) begin
                    check("t4.extra_pulse", 32'(k), 0);
                end else begin
                    check("t4.max", 32'(max_claimed_id), 32'(exp_max_q.pop_front()));
                    check("t4.count", 32'(claimed_count), 32'(exp_cnt_q.pop_front()));
                end
            end
        end
        check("t4.pulses", 32'(pulses), 2);
        check("t4.first_at", 32'(first_at), 66);
        check("t4.second_at", 32'(second_at), 132);
        check("t4.queue_left", 32'(exp_max_q.size()), 0);

        // T5: reset mid-scan aborts without scan_done
        fill_table(2'b10);
        set_entry(10, 2'b01);
        done_seen = 0;
        repeat (2) @(negedge clk);
        dplca_txop_table_upd = 1'b1;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            if (k == 1) dplca_txop_table_upd = 1'b0;
            if (k == 10) check("t5.busy_mid", 32'(scan_busy), 1);
            if (k == 41) begin
                check("t5.busy_after_rst", 32'(scan_busy), 0);
                check("t5.nc_after_rst", 32'(node_count), 8);
                check("t5.max_after_rst", 32'(max_claimed_id), 0);
                reset = 1'b0;
            end
            if (k == 40) reset = 1'b1;
            if (scan_done) done_seen++;
        end
        check("t5.no_done", 32'(done_seen), 0);

        // T5b / margin: ID10 HARD only
        scan_and_wait("t5b");
        check_results("t5b", 1, 10, 1, 1, 1, 11 + EXTRA);

        // T6: dplca_enable low mid-scan aborts and restores reset values
        done_seen = 0;
        repeat (2) @(negedge clk);
        dplca_txop_table_upd = 1'b1;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            if (k == 1) dplca_txop_table_upd = 1'b0;
            if (k == 26) begin
                check("t6.busy", 32'(scan_busy), 0);
                check("t6.any", 32'(any_claimed), 0);
                check("t6.nc", 32'(node_count), 8);
                dplca_enable = 1'b1;
            end
            if (k == 25) dplca_enable = 1'b0;
            if (scan_done) done_seen++;
        end
        check("t6.no_done", 32'(done_seen), 0);

        // Final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
